fletcher32_appender: RTL and testbench
======================================

Name: fletcher32_appender

Overview:
Synthesizable streaming stage that sits directly upstream of the word sink/validator in the image-to-SD write path. Forwards a fixed-length stream of 16-bit words unchanged. Accumulates a Fletcher-32 checksum over the stream, treating each word as a little-endian uint16. Appends the checksum as two trailing 16-bit words in the exact byte order the host-side reader expects.

Parameters:
LenWidth, 32, width of the per-transfer word-count input.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
start  input  1  single-cycle pulse; begins a transfer when idle
len  input  LenWidth  number of data words in the transfer; sampled on the accepted start
busy  output  1  high from the accepted start until the last checksum word is transferred
done  output  1  one-cycle pulse on the cycle after the second checksum word transfers
in_data  input  16  upstream data word, raw bus byte order
in_valid  input  1  upstream word valid
in_ready  output  1  stage accepts in_data
out_data  output  16  downstream word
out_valid  output  1  downstream word valid
out_ready  input  1  downstream accepts out_data

Behaviour:
- Transfer rule: a word transfers on a rising clk edge when valid && ready are both high. Data/valid must hold until the transfer.
- Reset (async assert): state=Idle; busy=0, done=0, in_ready=0, out_valid=0, out_data=0; sum1=sum2=0; counter=0.
- State Idle: start=1 latches len into remaining, clears sum1/sum2 and sets busy=1. Next state is Data, or Ck0 if len==0. Any start outside Idle is ignored.
- State Data, pass-through (no macro):
  - in_ready=out_ready.
  - out_valid=in_valid.
  - out_data=in_data.
  - Zero latency.
- State Data, per transfer:
  - v = {in_data[7:0], in_data[15:8]}.
  - sum1' = add65535(sum1, v).
  - sum2' = add65535(sum2, sum1').
  - remaining decrements by 1.
  - When remaining reaches 0, next state is Ck0.
- add65535(a,b): 17-bit sum s=a+b. If s>=0xFFFF, result is s-0xFFFF; otherwise result is s. Results always lie in 0..0xFFFE, so input 0xFFFF contributes 0.
- Checksum value: C = {sum2, sum1} after the last data word.
- State Ck0: in_ready=0, out_valid=1, out_data={C[7:0], C[15:8]}. On transfer, next state is Ck1.
- State Ck1: out_valid=1, out_data={C[23:16], C[31:24]}. On transfer, next state is Idle, busy=0, and done pulses next cycle.
- Host interpretation: the host reads the two words as a little-endian uint32 and obtains C.
- Empty transfer (len==0): emits exactly two words, 0x0000 and 0x0000.
- Backpressure:
  - out_ready low holds state, sums and out_data stable.
  - in_ready follows out_ready, so no words are lost or duplicated.
- Upstream idle: in_valid low in Data produces no transfer, no sum update and out_valid=0.
- Word count: exactly len+2 words are emitted per transfer. Extra upstream words are not accepted, because in_ready=0 outside Data.
- Sampling: len and start are sampled only in Idle. Changing len mid-transfer has no effect.
- Reset mid-transfer: immediate return to reset values. The partial checksum is discarded and no trailing words are emitted.

Optional Feature:
FLETCHER32_APPENDER_OUTREG_EN
- Defined: out_data/out_valid are driven from a 2-entry skid buffer.
  - Data latency from input transfer to out_valid is 1 cycle.
  - Full throughput under continuous valid/ready.
  - in_ready depends only on buffer occupancy: high when fewer than 2 entries are held. No combinational path from out_ready to in_ready.
  - Checksum words enter the same buffer, so ordering is preserved.
  - Buffer clears on reset.
- Undefined: combinational pass-through as described above, no extra registers.
- Both builds: emitted word sequence and done semantics are identical. Only cycle timing differs.

Test Plan:
- len=2, in_data 0x0100,0x0200, out_ready=1 -> out stream 0x0100,0x0200,0x0300,0x0400; done pulses once; busy low afterwards.
- len=2, in_data 0xFFFF,0x0100 -> trailing words 0x0100,0x0100 (0xFFFF reduces to 0 mod 65535).
- len=0, start -> exactly 0x0000,0x0000 emitted, then done; in_ready never high.
- len=1000 ramp (little-endian value increments by 1 per word); random in_valid/out_ready toggling -> output identical to input plus correct C, checked against a host model; no stalls lose words.
- start pulsed again while busy, and len changed mid-stream -> ignored; exactly len_original+2 words emitted.
- rst asserted after 5 of 10 words -> outputs return to reset values the same cycle; a new len=2 transfer then yields a fresh correct checksum.

Source files
------------

// File: rtl/fletcher32_appender_if.sv
// Valid/ready word stream between pipeline stages of the image-to-SD write path.
// The master drives data/valid, the slave drives ready; a word moves on a
// rising clock edge when valid and ready are both high.
interface fletcher32_appender_if;
   logic [15:0] data;
   logic        valid;
   logic        ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/fletcher32_appender.sv
// Streaming Fletcher-32 appender. Forwards len 16-bit words unchanged and then
// appends the checksum {sum2, sum1} as two trailing words in host byte order.
// Each incoming word is read as a little-endian uint16 (bytes swapped from the
// raw bus order) before it is accumulated.
//
// Build option FLETCHER32_APPENDER_OUTREG_EN: when defined, the output side is
// a 2-entry skid buffer, so in_ready no longer depends on out_ready. When it is
// undefined the data path is a zero-latency combinational pass-through.
module fletcher32_appender #(
   parameter int unsigned LenWidth = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LenWidth-1:0] len,
   output logic                busy,
   output logic                done,
   fletcher32_appender_if.slave  inStream,
   fletcher32_appender_if.master outStream
);

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StCk0,
      StCk1,
      StDrain
   } stateT;

   stateT               stateQ, stateD;
   logic [LenWidth-1:0] remainingQ, remainingD;
   logic [15:0]         sum1Q, sum1D;
   logic [15:0]         sum2Q, sum2D;
   logic                doneQ, doneD;

   // Word offered by the core (data or checksum) toward the output side.
   logic        coreValid;
   logic [15:0] coreData;
   logic        coreReady;
   logic        coreFire;
   logic        inFire;
   logic [15:0] inValue;
   logic [15:0] sum1Next;

   // Ones'-complement style addition modulo 65535; results stay in 0..0xFFFE.
   function automatic logic [15:0] add65535(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 17'h0FFFF) begin
         s = s - 17'h0FFFF;
      end
      return s[15:0];
   endfunction

   assign inValue  = {inStream.data[7:0], inStream.data[15:8]};
   assign sum1Next = add65535(sum1Q, inValue);

   assign inStream.ready = (stateQ == StData) && coreReady;
   assign inFire         = (stateQ == StData) && inStream.valid && coreReady;
   assign coreFire       = coreValid && coreReady;

   assign busy = (stateQ != StIdle);
   assign done = doneQ;

   // Select the word the core presents: live data, then the two checksum halves.
   always_comb begin
      coreValid = 1'b0;
      coreData  = 16'h0000;
      unique case (stateQ)
         StData: begin
            coreValid = inStream.valid;
            coreData  = inStream.data;
         end
         StCk0: begin
            coreValid = 1'b1;
            coreData  = {sum1Q[7:0], sum1Q[15:8]};
         end
         StCk1: begin
            coreValid = 1'b1;
            coreData  = {sum2Q[7:0], sum2Q[15:8]};
         end
         default: begin
            coreValid = 1'b0;
            coreData  = 16'h0000;
         end
      endcase
   end

`ifdef FLETCHER32_APPENDER_OUTREG_EN
   logic [15:0] buf0Q, buf0D;
   logic [15:0] buf1Q, buf1D;
   logic [1:0]  countQ, countD;
   logic [1:0]  afterPop;
   logic        push;
   logic        pop;

   assign coreReady        = (countQ != 2'd2);
   assign push             = coreFire;
   assign pop              = (countQ != 2'd0) && outStream.ready;
   assign outStream.valid  = (countQ != 2'd0);
   assign outStream.data   = buf0Q;
   assign afterPop         = countQ - {1'b0, pop};

   // Skid buffer next state: entry 0 is always the head; pops shift entry 1 down.
   always_comb begin
      buf0D  = buf0Q;
      buf1D  = buf1Q;
      countD = afterPop;
      if (pop) begin
         buf0D = buf1Q;
      end
      if (push) begin
         if (afterPop == 2'd0) begin
            buf0D = coreData;
         end else begin
            buf1D = coreData;
         end
         countD = afterPop + 2'd1;
      end
   end

   // Skid buffer storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf0Q  <= 16'h0000;
         buf1Q  <= 16'h0000;
         countQ <= 2'd0;
      end else begin
         buf0Q  <= buf0D;
         buf1Q  <= buf1D;
         countQ <= countD;
      end
   end
`else
   assign coreReady       = outStream.ready;
   assign outStream.valid = coreValid;
   assign outStream.data  = coreData;
`endif

   // Transfer sequencing and checksum accumulation.
   always_comb begin
      stateD     = stateQ;
      remainingD = remainingQ;
      sum1D      = sum1Q;
      sum2D      = sum2Q;
      doneD      = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (start) begin
               remainingD = len;
               sum1D      = 16'h0000;
               sum2D      = 16'h0000;
               stateD     = (len == '0) ? StCk0 : StData;
            end
         end
         StData: begin
            if (inFire) begin
               sum1D      = sum1Next;
               sum2D      = add65535(sum2Q, sum1Next);
               remainingD = remainingQ - LenWidth'(1);
               if (remainingQ == LenWidth'(1)) begin
                  stateD = StCk0;
               end
            end
         end
         StCk0: begin
            if (coreFire) begin
               stateD = StCk1;
            end
         end
         StCk1: begin
            if (coreFire) begin
`ifdef FLETCHER32_APPENDER_OUTREG_EN
               // Last word is queued; finish once it has left the buffer.
               stateD = StDrain;
`else
               stateD = StIdle;
               doneD  = 1'b1;
`endif
            end
         end
`ifdef FLETCHER32_APPENDER_OUTREG_EN
         StDrain: begin
            if ((pop && countQ == 2'd1) || countQ == 2'd0) begin
               stateD = StIdle;
               doneD  = 1'b1;
            end
         end
`endif
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   // State, counter, sums and done pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ     <= StIdle;
         remainingQ <= '0;
         sum1Q      <= 16'h0000;
         sum2Q      <= 16'h0000;
         doneQ      <= 1'b0;
      end else begin
         stateQ     <= stateD;
         remainingQ <= remainingD;
         sum1Q      <= sum1D;
         sum2Q      <= sum2D;
         doneQ      <= doneD;
      end
   end

endmodule

// File: tb/tb_fletcher32_appender.sv
// Self-checking bench for fletcher32_appender: randomized handshakes against a
// modular-arithmetic Fletcher-32 host model.
module tb_fletcher32_appender;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] lenSig;
   logic        busy;
   logic        done;
   int          checks;
   int          failures;

   fletcher32_appender_if inB ();
   fletcher32_appender_if outB ();

   fletcher32_appender #(
      .LenWidth(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (lenSig),
      .busy     (busy),
      .done     (done),
      .inStream (inB.slave),
      .outStream(outB.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Host view: forwarded words followed by the checksum halves in bus order.
   task automatic build_expected(input logic [15:0] words[$], output logic [15:0] exp[$]);
      int s1;
      int s2;
      logic [15:0] lo;
      logic [15:0] hi;
      s1 = 0;
      s2 = 0;
      exp = {};
      foreach (words[i]) begin
         s1 = (s1 + int'({words[i][7:0], words[i][15:8]})) % 65535;
         s2 = (s2 + s1) % 65535;
         exp.push_back(words[i]);
      end
      lo = s1[15:0];
      hi = s2[15:0];
      exp.push_back({lo[7:0], lo[15:8]});
      exp.push_back({hi[7:0], hi[15:8]});
   endtask

   // Runs one transfer with random valid/ready; collects every output transfer.
   task automatic run_xfer(input int unsigned n, input logic [15:0] words[$], input int vPct,
                           input int rPct, input bit mischief, output logic [15:0] got[$],
                           output int doneCnt, output bit timedOut, output bit sawInReady);
      int idx;
      int cyc;
      int post;
      bit inF;
      bit outF;
      bit doneSeen;
      idx = 0; cyc = 0; post = 0; inF = 0; doneSeen = 0;
      got = {}; doneCnt = 0; timedOut = 0; sawInReady = 0;
      @(negedge clk);
      start = 1'b1; lenSig = n; inB.valid = 1'b0; outB.ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!timedOut && !(doneSeen && post >= 3)) begin
         if (inF) begin
            inB.valid = 1'b0;
            idx++;
         end
         if (done) begin
            doneCnt++;
            doneSeen = 1;
         end
         if (doneSeen) post++;
         start = mischief && busy && ($urandom_range(0, 7) == 0);
         if (mischief) lenSig = $urandom_range(0, 40);
         if (!inB.valid && idx < words.size() && $urandom_range(0, 99) < vPct) begin
            inB.valid = 1'b1;
            inB.data  = words[idx];
         end
         outB.ready = ($urandom_range(0, 99) < rPct);
         #1;
         inF  = inB.valid && inB.ready;
         outF = outB.valid && outB.ready;
         if (inB.ready) sawInReady = 1;
         if (outF) got.push_back(outB.data);
         @(negedge clk);
         cyc++;
         if (cyc > 20000) timedOut = 1;
      end
      start = 1'b0; inB.valid = 1'b0; outB.ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (inB.ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", inB.ready); end
      checks++; if (outB.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", outB.valid); end
      checks++; if (outB.data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h want=0000", outB.data); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] words[$];
      logic [15:0] got[$];
      int dc; bit to; bit sr;
      words = {16'h0100, 16'h0200};
      run_xfer(2, words, 100, 100, 0, got, dc, to, sr);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b want=0", to); end
      checks++; if (got.size() != 4) begin failures++; $display("FAIL basic_count got=%0d want=4", got.size()); end
      if (got.size() == 4) begin
         checks++; if (got[0] !== 16'h0100) begin failures++; $display("FAIL basic_w0 got=%h want=0100", got[0]); end
         checks++; if (got[1] !== 16'h0200) begin failures++; $display("FAIL basic_w1 got=%h want=0200", got[1]); end
         checks++; if (got[2] !== 16'h0300) begin failures++; $display("FAIL basic_ck0 got=%h want=0300", got[2]); end
         checks++; if (got[3] !== 16'h0400) begin failures++; $display("FAIL basic_ck1 got=%h want=0400", got[3]); end
      end
      checks++; if (dc != 1) begin failures++; $display("FAIL basic_done got=%0d want=1", dc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", busy); end
   endtask

   task automatic test_wrap();
      logic [15:0] words[$];
      logic [15:0] got[$];
      int dc; bit to; bit sr;
      words = {16'hFFFF, 16'h0100};
      run_xfer(2, words, 100, 100, 0, got, dc, to, sr);
      checks++; if (got.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d want=4", got.size()); end
      if (got.size() == 4) begin
         checks++; if (got[2] !== 16'h0100) begin failures++; $display("FAIL wrap_ck0 got=%h want=0100", got[2]); end
         checks++; if (got[3] !== 16'h0100) begin failures++; $display("FAIL wrap_ck1 got=%h want=0100", got[3]); end
      end
      checks++; if (dc != 1) begin failures++; $display("FAIL wrap_done got=%0d want=1", dc); end
   endtask

   task automatic test_empty();
      logic [15:0] words[$];
      logic [15:0] got[$];
      int dc; bit to; bit sr;
      words = {};
      run_xfer(0, words, 100, 70, 0, got, dc, to, sr);
      checks++; if (got.size() != 2) begin failures++; $display("FAIL empty_count got=%0d want=2", got.size()); end
      if (got.size() == 2) begin
         checks++; if (got[0] !== 16'h0000) begin failures++; $display("FAIL empty_ck0 got=%h want=0000", got[0]); end
         checks++; if (got[1] !== 16'h0000) begin failures++; $display("FAIL empty_ck1 got=%h want=0000", got[1]); end
      end
      checks++; if (sr !== 1'b0) begin failures++; $display("FAIL empty_in_ready got=%b want=0", sr); end
      checks++; if (dc != 1) begin failures++; $display("FAIL empty_done got=%0d want=1", dc); end
   endtask

   task automatic test_ramp();
      logic [15:0] words[$];
      logic [15:0] exp[$];
      logic [15:0] got[$];
      logic [15:0] v;
      int dc; bit to; bit sr; int bad;
      v = 16'($urandom_range(0, 65535));
      words = {};
      for (int i = 0; i < 1000; i++) begin
         words.push_back({v[7:0], v[15:8]});
         v = v + 16'd1;
      end
      build_expected(words, exp);
      run_xfer(1000, words, 60, 60, 0, got, dc, to, sr);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL ramp_timeout got=%b want=0", to); end
      checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL ramp_count got=%0d want=%0d", got.size(), exp.size()); end
      bad = 0;
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            failures++;
            if (bad < 5) $display("FAIL ramp_word%0d got=%h want=%h", i, got[i], exp[i]);
            bad++;
         end
      end
      checks++; if (dc != 1) begin failures++; $display("FAIL ramp_done got=%0d want=1", dc); end
   endtask

   task automatic test_restart_ignored();
      logic [15:0] words[$];
      logic [15:0] exp[$];
      logic [15:0] got[$];
      int dc; bit to; bit sr;
      words = {};
      for (int i = 0; i < 20; i++) words.push_back(16'($urandom_range(0, 65535)));
      build_expected(words, exp);
      run_xfer(20, words, 80, 70, 1, got, dc, to, sr);
      checks++; if (got.size() != 22) begin failures++; $display("FAIL restart_count got=%0d want=22", got.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin failures++; $display("FAIL restart_word%0d got=%h want=%h", i, got[i], exp[i]); end
      end
      checks++; if (dc != 1) begin failures++; $display("FAIL restart_done got=%0d want=1", dc); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] words[$];
      logic [15:0] exp[$];
      logic [15:0] got[$];
      int fired; int cyc; int dc; bit to; bit sr;
      @(negedge clk);
      start = 1'b1; lenSig = 10;
      @(negedge clk);
      start = 1'b0;
      fired = 0; cyc = 0;
      while (fired < 5 && cyc < 50) begin
         inB.valid = 1'b1; inB.data = 16'($urandom_range(1, 65535)); outB.ready = 1'b1;
         #1;
         if (inB.valid && inB.ready) fired++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (fired != 5) begin failures++; $display("FAIL midrst_fed got=%0d want=5", fired); end
      inB.valid = 1'b1; inB.data = 16'h1234;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
      checks++; if (outB.valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", outB.valid); end
      checks++; if (inB.ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b want=0", inB.ready); end
      checks++; if (outB.data !== 16'h0000) begin failures++; $display("FAIL midrst_out_data got=%h want=0000", outB.data); end
      @(negedge clk);
      rst = 1'b0; inB.valid = 1'b0; outB.ready = 1'b0;
      words = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      build_expected(words, exp);
      run_xfer(2, words, 100, 100, 0, got, dc, to, sr);
      checks++; if (got.size() != 4) begin failures++; $display("FAIL midrst_count got=%0d want=4", got.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin failures++; $display("FAIL midrst_word%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; start = 1'b0; lenSig = 32'd0;
      inB.valid = 1'b0; inB.data = 16'h0000; outB.ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_empty();
      test_ramp();
      test_restart_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
